// File: rtl/minterm_decoder_seq_if.sv
// minterm_decoder_seq_if
//   Signal bundle for the minterm decoder. N is the decoder input width and
//   M = 2^N is the number of decoder lines.
//
//   Control protocol (start/busy/done): start is a single-cycle request.
//   It is honoured only in the idle state, where busy is low. While busy is
//   high, start and mask_load have no effect. When a sweep ends, done is high
//   for exactly one cycle and busy is already low. table_out and ones_count
//   are valid from that cycle until the next accepted start.
//
//   fsm_state is a debug view of the controller: 0 = idle, 1 = sweep, 2 = done.
//
//   master: drives En, w, mask_load, mask_in, start; observes the outputs.
//   slave : the decoder itself.
interface minterm_decoder_seq_if #(
    parameter int N = 4
) ();
    localparam int M = 1 << N;

    logic           En;
    logic [N-1:0]   w;
    logic           mask_load;
    logic [M-1:0]   mask_in;
    logic           start;

    logic [M-1:0]   y;
    logic           f;
    logic           busy;
    logic           done;
    logic [M-1:0]   table_out;
    logic [N:0]     ones_count;
    logic [1:0]     fsm_state;

    modport master (
        output En, w, mask_load, mask_in, start,
        input  y, f, busy, done, table_out, ones_count, fsm_state
    );

    modport slave (
        input  En, w, mask_load, mask_in, start,
        output y, f, busy, done, table_out, ones_count, fsm_state
    );
endinterface

// File: rtl/minterm_decoder_seq.sv
// minterm_decoder_seq
//   Registered N-to-2^N one-hot decoder with a programmable minterm mask.
//   f is the OR of the decoder lines selected by the mask, i.e. mask[w].
//   A sweep mode walks every input code through the decode path, capturing
//   the resulting truth table and the number of selected minterms.
//
// Ports
//   clk  : rising-edge clock
//   rst  : asynchronous, active-high reset
//   bus  : slave side of minterm_decoder_seq_if
//            inputs : En, w, mask_load, mask_in, start
//            outputs: y, f, busy, done, table_out, ones_count, fsm_state
module minterm_decoder_seq #(
    parameter int N = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    minterm_decoder_seq_if.slave bus
);
    localparam int M = 1 << N;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SWEEP = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    // Decoder line 0; shifted by the address to form the one-hot word.
    localparam logic [M-1:0] LINE0 = {{(M-1){1'b0}}, 1'b1};

    logic [1:0]   state;
    logic [N-1:0] cnt;
    logic [M-1:0] mask;
    logic [M-1:0] y_q;
    logic         f_q;
    logic         busy_q;
    logic         done_q;
    logic [M-1:0] table_q;
    logic [N:0]   ones_q;

    // Normal-mode decode, shared by IDLE and the DONE->IDLE edge.
    logic [M-1:0] idle_y;
    logic         idle_f;
    // Selected minterm bit for the code currently being swept.
    logic         sweep_bit;
    logic         last_code;

    assign idle_y    = bus.En ? (LINE0 << bus.w) : '0;
    assign idle_f    = bus.En & mask[bus.w];
    assign sweep_bit = mask[cnt];
    assign last_code = &cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            cnt     <= '0;
            mask    <= '0;
            y_q     <= '0;
            f_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            table_q <= '0;
            ones_q  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    y_q    <= idle_y;
                    f_q    <= idle_f;
                    done_q <= 1'b0;
                    // A load and a start on the same edge are both taken;
                    // the sweep's first read of mask happens one edge later,
                    // so it sees the new value.
                    if (bus.mask_load) begin
                        mask <= bus.mask_in;
                    end
                    if (bus.start) begin
                        state   <= S_SWEEP;
                        busy_q  <= 1'b1;
                        cnt     <= '0;
                        table_q <= '0;
                        ones_q  <= '0;
                    end
                end

                S_SWEEP: begin
                    y_q          <= LINE0 << cnt;
                    f_q          <= sweep_bit;
                    table_q[cnt] <= sweep_bit;
                    ones_q       <= ones_q + (N+1)'(sweep_bit);
                    cnt          <= cnt + 1'b1;
                    if (last_code) begin
                        state  <= S_DONE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end
                end

                S_DONE: begin
                    state  <= S_IDLE;
                    done_q <= 1'b0;
                    y_q    <= idle_y;
                    f_q    <= idle_f;
                end

                default: begin
                    state  <= S_IDLE;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.y          = y_q;
    assign bus.f          = f_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.table_out  = table_q;
    assign bus.ones_count = ones_q;
    assign bus.fsm_state  = state;
endmodule

// File: tb/tb_minterm_decoder_seq.sv
module tb_minterm_decoder_seq;
    localparam int N = 4;
    localparam int M = 16;
    localparam int W = M + 3;

    logic clk = 1'b0;
    logic rst = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;

    logic [W-1:0] exp_q[$];
    logic [M-1:0] cur_mask = '0;

    minterm_decoder_seq_if #(.N(4)) bus4 ();
    minterm_decoder_seq_if #(.N(2)) bus2 ();

    minterm_decoder_seq #(.N(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
    minterm_decoder_seq #(.N(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    endtask

    function automatic logic [M-1:0] onehot(input int k);
        logic [M-1:0] v;
        v = 1;
        return v << k;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic idle_inputs();
        bus4.En = 1'b0; bus4.w = '0; bus4.mask_load = 1'b0; bus4.mask_in = '0; bus4.start = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic push_exp(input logic [M-1:0] y, input logic f, input logic busy, input logic done);
        exp_q.push_back({busy, done, f, y});
    endtask

    // One edge, then pop the oldest expectation and compare.
    task automatic step_check(input string tag);
        logic [W-1:0] e;
        tick();
        if (exp_q.size() == 0) begin
            check({tag, "_sb_underflow"}, 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_y"},    32'(bus4.y),    32'(e[M-1:0]));
            check({tag, "_f"},    32'(bus4.f),    32'(e[M]));
            check({tag, "_done"}, 32'(bus4.done), 32'(e[M+1]));
            check({tag, "_busy"}, 32'(bus4.busy), 32'(e[M+2]));
        end
    endtask

    task automatic load_mask(input logic [M-1:0] m);
        idle_inputs();
        bus4.mask_load = 1'b1;
        bus4.mask_in   = m;
        cur_mask       = m;
        push_exp('0, 1'b0, 1'b0, 1'b0);
        step_check("load");
        idle_inputs();
    endtask

    task automatic idle_decode(input logic en, input int wv, input string tag);
        idle_inputs();
        bus4.En = en;
        bus4.w  = 4'(wv);
        push_exp(en ? onehot(wv) : '0, en & cur_mask[wv], 1'b0, 1'b0);
        step_check(tag);
        idle_inputs();
    endtask

    // Full sweep; optionally loads m on the start edge, optionally tries a
    // load and a restart in the middle of the sweep.
    task automatic do_sweep(input logic [M-1:0] m, input bit load_same, input bit disturb, input string tag);
        int wv;
        idle_inputs();
        bus4.start = 1'b1;
        if (load_same) begin
            bus4.mask_load = 1'b1;
            bus4.mask_in   = m;
            cur_mask       = m;
        end
        push_exp('0, 1'b0, 1'b1, 1'b0);
        step_check({tag, "_start"});
        check({tag, "_state_sweep"}, 32'(bus4.fsm_state), 32'd1);
        for (int k = 0; k < M; k++) begin
            idle_inputs();
            bus4.En = 1'($urandom_range(0, 1));
            bus4.w  = 4'($urandom_range(0, M - 1));
            if (disturb && k == 5) begin
                bus4.start     = 1'b1;
                bus4.mask_load = 1'b1;
                bus4.mask_in   = ~cur_mask;
            end
            push_exp(onehot(k), cur_mask[k], (k < M - 1), (k == M - 1));
            step_check($sformatf("%s_k%0d", tag, k));
        end
        check({tag, "_table"}, 32'(bus4.table_out), 32'(cur_mask));
        check({tag, "_ones"},  32'(bus4.ones_count), 32'($countones(cur_mask)));
        check({tag, "_state_done"}, 32'(bus4.fsm_state), 32'd2);
        wv = $urandom_range(0, M - 1);
        idle_decode(1'b1, wv, {tag, "_resume"});
        check({tag, "_table_hold"}, 32'(bus4.table_out), 32'(cur_mask));
        check({tag, "_ones_hold"},  32'(bus4.ones_count), 32'($countones(cur_mask)));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_y"},     32'(bus4.y), 32'd0);
        check({tag, "_f"},     32'(bus4.f), 32'd0);
        check({tag, "_busy"},  32'(bus4.busy), 32'd0);
        check({tag, "_done"},  32'(bus4.done), 32'd0);
        check({tag, "_table"}, 32'(bus4.table_out), 32'd0);
        check({tag, "_ones"},  32'(bus4.ones_count), 32'd0);
        check({tag, "_state"}, 32'(bus4.fsm_state), 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int cycles;
        idle_inputs();
        bus2.En = 1'b0; bus2.w = '0; bus2.mask_load = 1'b0; bus2.mask_in = '0; bus2.start = 1'b0;

        #1 rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;

        // Normal decode, mask still zero.
        idle_decode(1'b1, 5, "idle_w5");
        idle_decode(1'b0, 5, "idle_en0");

        // Function with minterms 3,5,6.
        load_mask(16'h0068);
        idle_decode(1'b1, 3, "fn_w3");
        idle_decode(1'b1, 5, "fn_w5");
        idle_decode(1'b1, 6, "fn_w6");
        idle_decode(1'b1, 4, "fn_w4");
        for (int i = 0; i < 6; i++) begin
            idle_decode(1'($urandom_range(0, 1)), $urandom_range(0, M - 1), "fn_rand");
        end

        // Sweeps.
        do_sweep(16'h0068, 1'b0, 1'b0, "sw68");
        load_mask(16'hFFFF);
        do_sweep(16'hFFFF, 1'b0, 1'b0, "swFF");
        load_mask(16'h0000);
        do_sweep(16'h0000, 1'b0, 1'b0, "sw00");
        do_sweep(16'h00F0, 1'b1, 1'b0, "swF0_same");
        do_sweep(16'h00F0, 1'b0, 1'b1, "swF0_dist");

        // Reset in the middle of a sweep, after 7 sweep edges (cnt == 7).
        idle_inputs();
        bus4.start = 1'b1;
        push_exp('0, 1'b0, 1'b1, 1'b0);
        step_check("abort_start");
        for (int k = 0; k < 7; k++) begin
            idle_inputs();
            push_exp(onehot(k), cur_mask[k], 1'b1, 1'b0);
            step_check($sformatf("abort_k%0d", k));
        end
        rst = 1'b1;
        #1;
        check_all_zero("abort");
        @(negedge clk);
        rst = 1'b0;
        cur_mask = '0;
        idle_decode(1'b0, 0, "post_abort_a");
        idle_decode(1'b0, 0, "post_abort_b");
        idle_decode(1'b1, 5, "post_abort_mask_clr");
        load_mask(16'h0068);
        do_sweep(16'h0068, 1'b0, 1'b0, "sw_fresh");

        // N = 2 instance.
        bus2.mask_load = 1'b1;
        bus2.mask_in   = 4'b1001;
        tick();
        bus2.mask_load = 1'b0;
        bus2.start     = 1'b1;
        tick();
        bus2.start = 1'b0;
        check("n2_busy", 32'(bus2.busy), 32'd1);
        cycles = 0;
        while (cycles < 20 && bus2.done !== 1'b1) begin
            tick();
            cycles++;
        end
        check("n2_latency", 32'(cycles), 32'd4);
        check("n2_table",   32'(bus2.table_out), 32'd9);
        check("n2_ones",    32'(bus2.ones_count), 32'd2);
        check("n2_busy_end", 32'(bus2.busy), 32'd0);

        check("sb_leftover", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
